sap2_controller: RTL and testbench

//  Control unit fed by the 18-bit one-hot T-state ring counter. Latches the opcode into the

---
 rtl/sap2_pkg.sv | 102 ++++++++++
 rtl/sap2_ucode_rom.sv | 66 ++++++
 rtl/sap2_controller.sv | 112 +++++++++++
 tb/tb_sap2_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap2_pkg.sv
// SAP-II controller shared definitions: T-state one-hots, control-word bit map,
// opcodes, and instruction length / T-state decode helpers.
package sap2_pkg;

  localparam logic [17:0] T01 = 18'h00001;
  localparam logic [17:0] T02 = 18'h00002;
  localparam logic [17:0] T03 = 18'h00004;
  localparam logic [17:0] T04 = 18'h00008;
  localparam logic [17:0] T05 = 18'h00010;
  localparam logic [17:0] T06 = 18'h00020;
  localparam logic [17:0] T07 = 18'h00040;
  localparam logic [17:0] T08 = 18'h00080;
  localparam logic [17:0] T09 = 18'h00100;
  localparam logic [17:0] T10 = 18'h00200;
  localparam logic [17:0] T11 = 18'h00400;
  localparam logic [17:0] T12 = 18'h00800;
  localparam logic [17:0] T13 = 18'h01000;
  localparam logic [17:0] T14 = 18'h02000;
  localparam logic [17:0] T15 = 18'h04000;
  localparam logic [17:0] T16 = 18'h08000;
  localparam logic [17:0] T17 = 18'h10000;
  localparam logic [17:0] T18 = 18'h20000;

  localparam int unsigned CW_W = 14;
  typedef logic [CW_W-1:0] cw_t;

  localparam int unsigned CW_CP_IDX = 0;   // PC increment
  localparam int unsigned CW_EP_IDX = 1;   // PC onto W-bus
  localparam int unsigned CW_LM_IDX = 2;   // load MAR
  localparam int unsigned CW_CE_IDX = 3;   // memory onto W-bus
  localparam int unsigned CW_LI_IDX = 4;   // load IR
  localparam int unsigned CW_LP_IDX = 5;   // load PC from W-bus
  localparam int unsigned CW_LA_IDX = 6;   // load accumulator
  localparam int unsigned CW_EA_IDX = 7;   // accumulator onto W-bus
  localparam int unsigned CW_LB_IDX = 8;   // load B
  localparam int unsigned CW_EB_IDX = 9;   // B onto W-bus
  localparam int unsigned CW_ET_IDX = 10;  // TMP onto W-bus
  localparam int unsigned CW_LT_IDX = 11;  // load TMP
  localparam int unsigned CW_EU_IDX = 12;  // ALU onto W-bus
  localparam int unsigned CW_WE_IDX = 13;  // memory write

  localparam cw_t CW_IDLE = '0;
  localparam cw_t CW_CP = cw_t'(1 << CW_CP_IDX);
  localparam cw_t CW_EP = cw_t'(1 << CW_EP_IDX);
  localparam cw_t CW_LM = cw_t'(1 << CW_LM_IDX);
  localparam cw_t CW_CE = cw_t'(1 << CW_CE_IDX);
  localparam cw_t CW_LI = cw_t'(1 << CW_LI_IDX);
  localparam cw_t CW_LP = cw_t'(1 << CW_LP_IDX);
  localparam cw_t CW_LA = cw_t'(1 << CW_LA_IDX);
  localparam cw_t CW_EA = cw_t'(1 << CW_EA_IDX);
  localparam cw_t CW_LB = cw_t'(1 << CW_LB_IDX);
  localparam cw_t CW_EB = cw_t'(1 << CW_EB_IDX);
  localparam cw_t CW_ET = cw_t'(1 << CW_ET_IDX);
  localparam cw_t CW_LT = cw_t'(1 << CW_LT_IDX);
  localparam cw_t CW_EU = cw_t'(1 << CW_EU_IDX);
  localparam cw_t CW_WE = cw_t'(1 << CW_WE_IDX);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_MVI_B  = 8'h06;
  localparam logic [7:0] OP_STA    = 8'h32;
  localparam logic [7:0] OP_LDA    = 8'h3A;
  localparam logic [7:0] OP_MVI_A  = 8'h3E;
  localparam logic [7:0] OP_HLT    = 8'h76;
  localparam logic [7:0] OP_MOV_AB = 8'h78;
  localparam logic [7:0] OP_ADD_B  = 8'h80;
  localparam logic [7:0] OP_JNZ    = 8'hC2;
  localparam logic [7:0] OP_JMP    = 8'hC3;
  localparam logic [7:0] OP_JZ     = 8'hCA;
  localparam logic [7:0] OP_JM     = 8'hFA;

  function automatic logic is_cond_jump(input logic [7:0] op);
    return (op == OP_JZ) || (op == OP_JNZ) || (op == OP_JM);
  endfunction

  function automatic logic [4:0] instr_len(input logic [7:0] op, input logic taken);
    logic [4:0] len;
    case (op)
      OP_MVI_A, OP_MVI_B:   len = 5'd7;
      OP_LDA, OP_STA:       len = 5'd13;
      OP_JMP:               len = 5'd10;
      OP_JZ, OP_JNZ, OP_JM: len = taken ? 5'd10 : 5'd7;
      default:              len = 5'd4;
    endcase
    return len;
  endfunction

  // 1..18 for a one-hot input; 0 for zero or multi-hot.
  function automatic logic [4:0] t_index(input logic [17:0] oh);
    logic [4:0]  idx;
    int unsigned n;
    idx = '0;
    n   = 0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (oh[i]) begin
        idx = 5'(i + 1);
        n++;
      end
    end
    return (n == 1) ? idx : 5'd0;
  endfunction

endpackage

// File: rtl/sap2_ucode_rom.sv
// Combinational microcode: (opcode, T-state index, jump-taken) -> SAP-II control word.
module sap2_ucode_rom
  import sap2_pkg::*;
(
  input  logic [7:0]      op,
  input  logic [4:0]      t_idx,
  input  logic            taken,
  output logic [CW_W-1:0] cw
);

  always_comb begin
    cw = CW_IDLE;
    if (t_idx == 5'd1)      cw = CW_EP | CW_LM;
    else if (t_idx == 5'd2) cw = CW_CP;
    else if (t_idx == 5'd3) cw = CW_CE | CW_LI;
    else begin
      case (op)
        OP_MVI_A, OP_MVI_B: begin
          case (t_idx)
            5'd4:    cw = CW_EP | CW_LM;
            5'd5:    cw = CW_CE | ((op == OP_MVI_A) ? CW_LA : CW_LB);
            5'd6:    cw = CW_CP;
            default: cw = CW_IDLE;
          endcase
        end
        OP_LDA, OP_STA: begin
          case (t_idx)
            5'd4, 5'd7: cw = CW_EP | CW_LM;
            5'd5, 5'd8: cw = CW_CE | CW_LT;
            5'd6, 5'd9: cw = CW_CP;
            5'd10:      cw = CW_ET | CW_LM;
            5'd11:      cw = (op == OP_LDA) ? (CW_CE | CW_LA) : (CW_EA | CW_WE);
            default:    cw = CW_IDLE;
          endcase
        end
        OP_JMP: begin
          case (t_idx)
            5'd4, 5'd7: cw = CW_EP | CW_LM;
            5'd5, 5'd8: cw = CW_CE | CW_LT;
            5'd6:       cw = CW_CP;
            5'd9:       cw = CW_ET | CW_LP;
            default:    cw = CW_IDLE;
          endcase
        end
        // T4 is idle: the branch decision only becomes visible from T5.
        OP_JZ, OP_JNZ, OP_JM: begin
          if (taken) begin
            case (t_idx)
              5'd5, 5'd8: cw = CW_EP | CW_LM;
              5'd6, 5'd9: cw = CW_CE | CW_LT;
              5'd7:       cw = CW_CP;
              5'd10:      cw = CW_ET | CW_LP;
              default:    cw = CW_IDLE;
            endcase
          end else if (t_idx == 5'd5 || t_idx == 5'd6) begin
            cw = CW_CP;
          end
        end
        OP_ADD_B:  if (t_idx == 5'd4) cw = CW_EU | CW_LA;
        OP_MOV_AB: if (t_idx == 5'd4) cw = CW_EB | CW_LA;
        default:   cw = CW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sap2_controller.sv
// SAP-II control unit: IR, jump/halt tracking, retired-instruction count and ring-clear.
// Optional SAP2_CTRL_ONEHOT_CHECK_EN: illegal t_state sets sticky fault and halted.
module sap2_controller
  import sap2_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter logic [7:0]  NOP_OP = 8'h00
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic [17:0]      t_state,
  input  logic [7:0]       wbus_in,
  input  logic             flag_z,
  input  logic             flag_s,
  output logic [CW_W-1:0]  ctrl_word,
  output logic             ring_nclr,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             fault
);

  logic [4:0]       t_idx, len;
  logic             legal, active, terminal, past_end, cond;
  logic [CW_W-1:0]  rom_cw;
  logic [7:0]       ir_q, ir_d;
  logic             taken_q, taken_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  sap2_ucode_rom u_rom (
    .op    (ir_q),
    .t_idx (t_idx),
    .taken (taken_q),
    .cw    (rom_cw)
  );

  always_comb begin
    t_idx    = t_index(t_state);
    len      = instr_len(ir_q, taken_q);
    legal    = (t_idx != 5'd0);
    active   = legal && !halted_q;
    terminal = legal && (t_idx == len);
    past_end = legal && (t_idx > len);
    case (ir_q)
      OP_JZ:   cond = flag_z;
      OP_JNZ:  cond = !flag_z;
      OP_JM:   cond = flag_s;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_word = CW_IDLE;
    ring_nclr = 1'b0;
    if (nCLR && active && !past_end) begin
      ctrl_word = rom_cw;
      ring_nclr = !terminal;
    end
  end

  always_comb begin
    ir_d        = ir_q;
    taken_d     = taken_q;
    halted_d    = halted_q;
    instr_cnt_d = instr_cnt_q;
    if (active) begin
      if (t_idx == 5'd3) ir_d = wbus_in;
      if (t_idx == 5'd4 && is_cond_jump(ir_q)) taken_d = cond;
      if (t_idx == 5'd4 && ir_q == OP_HLT) halted_d = 1'b1;
      if (terminal) begin
        taken_d = 1'b0;
        if (ir_q != OP_HLT) instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
    end
`ifdef SAP2_CTRL_ONEHOT_CHECK_EN
    if (!legal) halted_d = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      ir_q        <= NOP_OP;
      taken_q     <= 1'b0;
      halted_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      ir_q        <= ir_d;
      taken_q     <= taken_d;
      halted_q    <= halted_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

`ifdef SAP2_CTRL_ONEHOT_CHECK_EN
  logic fault_q, fault_d;

  always_comb fault_d = fault_q | !legal;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign halted    = halted_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_sap2_controller.sv
// Scoreboard bench for sap2_controller: the stimulus side plays ring counter and
// pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_sap2_controller;
  import sap2_pkg::*;

  localparam int unsigned TB_CNT_W = 8;

  logic                CLK  = 1'b0;
  logic                nCLR = 1'b0;
  logic [17:0]         t_state = 18'h00001;
  logic [7:0]          wbus_in = 8'h00;
  logic                flag_z = 1'b0;
  logic                flag_s = 1'b0;
  logic [CW_W-1:0]     ctrl_word;
  logic                ring_nclr, halted, fault;
  logic [TB_CNT_W-1:0] instr_cnt;

  sap2_controller #(.CNT_W(TB_CNT_W), .NOP_OP(8'h00)) dut (
    .CLK       (CLK),
    .nCLR      (nCLR),
    .t_state   (t_state),
    .wbus_in   (wbus_in),
    .flag_z    (flag_z),
    .flag_s    (flag_s),
    .ctrl_word (ctrl_word),
    .ring_nclr (ring_nclr),
    .halted    (halted),
    .instr_cnt (instr_cnt),
    .fault     (fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [CW_W-1:0]     cw;
    logic [CW_W-1:0]     mask;
    logic                rn;
    logic                hl;
    logic                flt;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int   m_cnt    = 0;
  bit   m_halted = 1'b0;
  bit   m_fault  = 1'b0;

  logic [7:0] known_ops [12] = '{8'h00, 8'h06, 8'h32, 8'h3A, 8'h3E, 8'h76,
                                 8'h78, 8'h80, 8'hC2, 8'hC3, 8'hCA, 8'hFA};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ring_nclr", 32'(ring_nclr), 32'(e.rn));
      chk("halted",    32'(halted),    32'(e.hl));
      chk("fault",     32'(fault),     32'(e.flt));
      chk("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
      if (e.mask != '0) chk("ctrl_word", 32'(ctrl_word & e.mask), 32'(e.cw & e.mask));
    end
  end

  function automatic bit is_jcc(input logic [7:0] op);
    return op == 8'hCA || op == 8'hC2 || op == 8'hFA;
  endfunction

  function automatic bit is_known(input logic [7:0] op);
    foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_len(input logic [7:0] op, input bit tk);
    if (op == 8'h3E || op == 8'h06) return 7;
    if (op == 8'h3A || op == 8'h32) return 13;
    if (op == 8'hC3) return 10;
    if (is_jcc(op)) return tk ? 10 : 7;
    return 4;
  endfunction

  function automatic logic [17:0] onehot(input int t);
    logic [17:0] one;
    one = 18'h00001;
    return one << (t - 1);
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.cw   = CW_IDLE;
    e.mask = '0;
    e.rn   = 1'b0;
    e.hl   = m_halted;
    e.flt  = m_fault;
    e.cnt  = TB_CNT_W'(m_cnt);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.cw   = CW_IDLE;
    e.mask = '1;
    e.rn   = 1'b0;
    e.hl   = 1'b0;
    e.flt  = 1'b0;
    e.cnt  = '0;
    return e;
  endfunction

  task automatic cycle(input logic [17:0] tv, input logic [7:0] wb, input logic fz,
                       input logic fs, input exp_t e);
    t_state = tv;
    wbus_in = wb;
    flag_z  = fz;
    flag_s  = fs;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    nCLR = 1'b0;
    model_reset();
    repeat (ncyc) cycle(onehot(1), 8'h00, 1'b0, 1'b0, reset_exp());
    nCLR = 1'b1;
  endtask

  // fsel: 0/1 forces flag_z, 2 randomises; abort_t drops nCLR mid-way through that T-state.
  task automatic run_instr(input logic [7:0] op, input int fsel, input int abort_t);
    int   len;
    bit   tk, was_h;
    logic fz, fs;
    exp_t e;
    was_h = m_halted;
    tk    = 1'b0;
    len   = ref_len(op, 1'b0);
    for (int t = 1; t <= len; t++) begin
      fz = (fsel == 2) ? 1'($urandom_range(1)) : 1'(fsel);
      fs = 1'($urandom_range(1));
      e  = model_exp();
      if (m_halted) begin
        e.mask = '1;
      end else begin
        if (t == 4 && is_jcc(op)) begin
          tk  = (op == 8'hCA) ? fz : (op == 8'hC2) ? !fz : fs;
          len = ref_len(op, tk);
        end
        e.rn = (t != len);
        if (t == 1) begin e.cw = CW_EP | CW_LM; e.mask = '1; end
        if (t == 2) begin e.cw = CW_CP;         e.mask = '1; end
        if (t == 3) begin e.cw = CW_CE | CW_LI; e.mask = '1; end
        if (t == 4 && !is_known(op)) e.mask = '1;
        if (is_jcc(op) && !tk && (t == 5 || t == 6)) begin
          e.cw   = CW_CP;
          e.mask = CW_CP;
        end
      end
      if (t == abort_t) begin
        t_state = onehot(t);
        wbus_in = 8'($urandom);
        #1;
        nCLR = 1'b0;
        model_reset();
        sb.push_back(reset_exp());
        @(posedge CLK);
        #1;
        cycle(onehot(1), 8'h00, 1'b0, 1'b0, reset_exp());
        nCLR = 1'b1;
        return;
      end
      cycle(onehot(t), (t == 3) ? op : 8'($urandom), fz, fs, e);
      if (!m_halted && t == 4 && op == 8'h76) m_halted = 1'b1;
    end
    if (!was_h && op != 8'h76) m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
  endtask

  task automatic bad_tstate(input logic [17:0] tv);
    exp_t e;
    e      = model_exp();
    e.mask = '1;
    cycle(tv, 8'($urandom), 1'b0, 1'b0, e);
`ifdef SAP2_CTRL_ONEHOT_CHECK_EN
    m_halted = 1'b1;
    m_fault  = 1'b1;
`endif
  endtask

  task automatic out_of_sync(input int t);
    exp_t e;
    e      = model_exp();
    e.mask = '1;
    cycle(onehot(t), 8'($urandom), 1'b0, 1'b0, e);
  endtask

  task automatic park(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e      = model_exp();
      e.mask = m_halted ? '1 : '0;
      e.rn   = !m_halted;
      cycle(onehot(1), 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), e);
    end
  endtask

  initial begin
    logic [7:0] op;
    @(posedge CLK);
    #1;
    do_reset(2);

    run_instr(8'h3E, 2, 0);
    out_of_sync(8);
    run_instr(8'hCA, 1, 0);
    run_instr(8'hCA, 0, 0);
    run_instr(8'hC2, 2, 0);
    run_instr(8'hFA, 2, 0);
    run_instr(8'h55, 2, 0);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(3) != 0) ? known_ops[$urandom_range(11)] : 8'($urandom);
      if (op == 8'h76) op = 8'h00;
      run_instr(op, 2, 0);
    end

    while (m_cnt != (1 << TB_CNT_W) - 1) run_instr(8'h00, 2, 0);
    run_instr(8'h00, 2, 0);
    run_instr(8'h00, 2, 0);

    run_instr(8'h3A, 2, 9);
    run_instr(8'h3E, 2, 0);

    bad_tstate(18'h00000);
    bad_tstate(18'h00003);
    run_instr(8'h00, 2, 0);

    run_instr(8'h76, 2, 0);
    park(20);

    do_reset(1);
    run_instr(8'h06, 2, 0);
    park(1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
